display_scan_scheduler: RTL and testbench
=========================================

Name: display_scan_scheduler

Overview:
- Time-multiplexes the 4-digit seven-segment display of the vending machine and arbitrates it between two sources.
- The default source is the 4-digit BCD credit/price value. An overlay source (error or "sold out" codes) takes the display for a fixed number of frames through a request/acknowledge handshake.
- Drives the digit enables and the per-digit nibble that feeds the seven-segment decoder.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; must be >= 2.
- HOLD_FRAMES, 200: number of full frames an accepted message is shown; must be >= 1.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous reset, active-high.
- CreditData  input  16  default source, 4 BCD digits; [3:0] = digit 1 (rightmost), [15:12] = digit 4.
- BlankZero  input  1  enables leading-zero blanking on the credit source.
- MsgData  input  16  overlay source, same digit packing.
- MsgReq  input  1  overlay request level; held until acknowledged.
- MsgAck  output  1  one-cycle pulse when the request is accepted.
- Busy  output  1  high while the overlay owns the display (accepted, not yet released).
- Digits  output  4  [4:1] digit enables, active-low, at most one low.
- Nibble  output  4  value for the active digit, passed to the decoder.
- Blank  output  1  high when the current slot is blanked (Digits = 4'b1111).
- FrameTick  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async, immediate):
  - Prescaler = 0, slot = 4, state = IDLE, HoldCnt = 0, snapshot = 0.
  - Outputs: Digits = 4'b1111, Nibble = 0, Blank = 1, MsgAck = 0, Busy = 0, FrameTick = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - Terminal count (TC) occurs when the count equals SCAN_DIV-1.
- Slot advance:
  - At each TC the slot advances 1->2->3->4->1.
  - The first TC after reset moves slot 4->1, so it is a frame boundary.
  - Frame boundary = TC with slot 4->1; FrameTick is high in the cycle after it.
  - Frame period = 4*SCAN_DIV cycles.
- Registered outputs:
  - Digits, Nibble and Blank update on the TC edge and hold for the whole slot.
  - Slot k drives Digits bit k low, with Nibble = snapshot digit k.
- Snapshot:
  - A 16-bit display register loaded only at frame boundaries, from the source selected at that edge.
  - Source changes never tear mid-frame.
  - The snapshot also records whether it came from the credit source, for blanking.
- Leading-zero blanking (credit snapshot with BlankZero = 1 only):
  - Digit k (k = 4..2) is blanked when it and every higher digit are 0.
  - Digit 1 is never blanked.
  - A blanked slot gives Digits = 4'b1111, Blank = 1, Nibble = 0.
  - Message snapshots are never blanked.
  - BlankZero is sampled per slot.
- Non-BCD nibbles (A-F) pass through unchanged.
- Arbiter FSM, IDLE state:
  - MsgReq = 1 sampled at an edge: latch MsgData into MsgShadow, HoldCnt = HOLD_FRAMES, go to MSG.
  - MsgAck = 1 for exactly one cycle after that edge; Busy = 1 from that cycle.
- Arbiter FSM, MSG state:
  - MsgReq is ignored and not acknowledged; it stays pending.
  - At each frame boundary with HoldCnt != 0: snapshot = MsgShadow, HoldCnt -= 1.
  - At a frame boundary with HoldCnt == 0: snapshot = CreditData, go to IDLE, Busy = 0 after that edge.
  - MsgData changes after acceptance have no effect.
- Simultaneous events:
  - Acceptance on a frame-boundary edge: that boundary still loads credit (state was IDLE); the message shows from the next boundary.
  - MsgReq still high on the release edge: not accepted on that edge; accepted at the next edge in IDLE. MsgAck appears 1 cycle after Busy falls.
- Net timing: the message is displayed for exactly HOLD_FRAMES full frames.

Test Plan:
- Use SCAN_DIV = 4, HOLD_FRAMES = 2 for all scenarios.
1. Reset release, CreditData = 16'h0105, BlankZero = 1 -> FrameTick after cycle 4. Slots show:
   - Digits 1110 / Nibble 5
   - Digits 1101 / Nibble 0 (not blanked, digit 3 nonzero)
   - Digits 1011 / Nibble 1
   - Digits 1111 / Blank 1
2. CreditData = 16'h0007: BlankZero = 1 -> only digit 1 lit, Nibble 7. BlankZero = 0 -> all four lit, Nibble 0,0,0 on digits 2-4.
3. MsgReq = 1, MsgData = 16'hE770 mid-frame -> MsgAck single pulse, Busy = 1. The next 2 frames show 0,7,7,E with no blanking. The third boundary restores credit, Busy = 0, exactly 8*SCAN_DIV cycles after the first message boundary.
4. MsgReq held continuously through scenario 3 -> no second MsgAck while Busy. A second MsgAck arrives 1 cycle after Busy falls, with a new message the next frame.
5. CreditData changes 16'h0105 -> 16'h0230 mid-frame -> the remaining slots still show 0105; 0230 appears only after the next FrameTick.
6. Assert Reset mid-message during slot 2 -> same cycle: Digits = 1111, Busy = 0, MsgAck = 0, Blank = 1. After release, the first frame shows credit.

Source files
------------

// File: rtl/display_scan_scheduler.sv
// Four-digit seven-segment scan scheduler with a frame-locked snapshot and a
// request/acknowledge overlay arbiter (credit display vs. timed message display).
module display_scan_scheduler #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned HOLD_FRAMES = 200
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] CreditData,
    input  logic        BlankZero,
    input  logic [15:0] MsgData,
    input  logic        MsgReq,
    output logic        MsgAck,
    output logic        Busy,
    output logic [3:0]  Digits,
    output logic [3:0]  Nibble,
    output logic        Blank,
    output logic        FrameTick
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic {IDLE, MSG} state_t;

    state_t        state, state_next;
    logic [CW-1:0] presc;
    logic [1:0]    slot;          // 0..3 selects digit 1..4
    logic [1:0]    slot_next;
    logic [HW-1:0] hold, hold_next;
    logic [15:0]   shadow, shadow_next;
    logic [15:0]   snap, snap_next;
    logic          snap_credit, snap_credit_next;
    logic          accept;
    logic          tc, boundary;
    logic [3:0]    digit_val;
    logic          digit_blank;
    logic          z4, z3, z2;

    assign tc        = (presc == CW'(SCAN_DIV - 1));
    assign slot_next = slot + 2'd1;
    assign boundary  = tc && (slot == 2'd3);
    assign Busy      = (state == MSG);

    always_comb begin
        state_next       = state;
        hold_next        = hold;
        shadow_next      = shadow;
        snap_next        = snap;
        snap_credit_next = snap_credit;
        accept           = 1'b0;
        case (state)
            IDLE: begin
                if (boundary) begin
                    snap_next        = CreditData;
                    snap_credit_next = 1'b1;
                end
                if (MsgReq) begin
                    accept      = 1'b1;
                    shadow_next = MsgData;
                    hold_next   = HW'(HOLD_FRAMES);
                    state_next  = MSG;
                end
            end
            MSG: begin
                if (boundary) begin
                    if (hold != '0) begin
                        snap_next        = shadow;
                        snap_credit_next = 1'b0;
                        hold_next        = hold - HW'(1);
                    end else begin
                        snap_next        = CreditData;
                        snap_credit_next = 1'b1;
                        state_next       = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The slot entered on this TC is rendered from the snapshot as it will be
    // after this edge, so the first slot of a frame already sees the new frame.
    always_comb begin
        z4        = (snap_next[15:12] == 4'd0);
        z3        = z4 && (snap_next[11:8] == 4'd0);
        z2        = z3 && (snap_next[7:4] == 4'd0);
        digit_val = snap_next[{slot_next, 2'b00} +: 4];
        case (slot_next)
            2'd1:    digit_blank = z2;
            2'd2:    digit_blank = z3;
            2'd3:    digit_blank = z4;
            default: digit_blank = 1'b0;
        endcase
        digit_blank = digit_blank && snap_credit_next && BlankZero;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            hold        <= '0;
            shadow      <= '0;
            snap        <= '0;
            snap_credit <= 1'b0;
        end else begin
            state       <= state_next;
            hold        <= hold_next;
            shadow      <= shadow_next;
            snap        <= snap_next;
            snap_credit <= snap_credit_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc     <= '0;
            slot      <= 2'd3;
            Digits    <= '1;
            Nibble    <= '0;
            Blank     <= 1'b1;
            FrameTick <= 1'b0;
            MsgAck    <= 1'b0;
        end else begin
            presc     <= tc ? '0 : presc + CW'(1);
            FrameTick <= boundary;
            MsgAck    <= accept;
            if (tc) begin
                slot   <= slot_next;
                Blank  <= digit_blank;
                Digits <= digit_blank ? 4'b1111 : ~(4'b0001 << slot_next);
                Nibble <= digit_blank ? 4'd0 : digit_val;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench for display_scan_scheduler: a cycle model pushes expected
// outputs at each rising edge, the monitor pops and compares on the falling edge.
module tb_display_scan_scheduler;

    localparam int SD = 4;
    localparam int HF = 2;

    logic        clk = 1'b0;
    logic        Reset;
    logic [15:0] CreditData;
    logic        BlankZero;
    logic [15:0] MsgData;
    logic        MsgReq;
    logic        MsgAck;
    logic        Busy;
    logic [3:0]  Digits;
    logic [3:0]  Nibble;
    logic        Blank;
    logic        FrameTick;

    display_scan_scheduler #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
        .Clk(clk), .Reset(Reset), .CreditData(CreditData), .BlankZero(BlankZero),
        .MsgData(MsgData), .MsgReq(MsgReq), .MsgAck(MsgAck), .Busy(Busy),
        .Digits(Digits), .Nibble(Nibble), .Blank(Blank), .FrameTick(FrameTick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] digits;
        logic [3:0] nibble;
        logic       blank;
        logic       ack;
        logic       busy;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   extra_acks = 0;
    logic busy_prev = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model, reasoning in digit numbers 1..4 and frames.
    int          m_cnt, m_slot, m_hold;
    logic        m_busy, m_cred;
    logic [15:0] m_shadow, m_snap;
    exp_t        m_e;

    task automatic model_reset();
        m_cnt = 0; m_slot = 4; m_hold = 0; m_busy = 1'b0; m_cred = 1'b0;
        m_shadow = '0; m_snap = '0;
        m_e = '{digits: 4'hF, nibble: 4'h0, blank: 1'b1, ack: 1'b0, busy: 1'b0, tick: 1'b0};
    endtask

    always @(posedge clk) begin
        logic old_busy, was_tc, blank_it;
        logic [15:0] sh;
        if (Reset) begin
            model_reset();
        end else begin
            old_busy = m_busy;
            m_e.tick = 1'b0;
            m_e.ack  = 1'b0;
            was_tc   = (m_cnt == SD - 1);
            m_cnt    = was_tc ? 0 : m_cnt + 1;
            if (was_tc) begin
                if (m_slot == 4) begin
                    m_slot   = 1;
                    m_e.tick = 1'b1;
                    if (old_busy && m_hold > 0) begin
                        m_snap = m_shadow; m_cred = 1'b0; m_hold--;
                    end else begin
                        m_snap = CreditData; m_cred = 1'b1;
                        if (old_busy) m_busy = 1'b0;
                    end
                end else begin
                    m_slot++;
                end
                blank_it = m_cred && BlankZero && (m_slot > 1);
                for (int j = m_slot; j <= 4; j++) begin
                    sh = m_snap >> (4 * (j - 1));
                    if (sh[3:0] != 4'd0) blank_it = 1'b0;
                end
                sh = m_snap >> (4 * (m_slot - 1));
                m_e.blank  = blank_it;
                m_e.nibble = blank_it ? 4'd0 : sh[3:0];
                case (m_slot)
                    1: m_e.digits = 4'b1110;
                    2: m_e.digits = 4'b1101;
                    3: m_e.digits = 4'b1011;
                    default: m_e.digits = 4'b0111;
                endcase
                if (blank_it) m_e.digits = 4'b1111;
            end
            if (!old_busy && MsgReq) begin
                m_shadow = MsgData; m_hold = HF; m_busy = 1'b1; m_e.ack = 1'b1;
            end
            m_e.busy = m_busy;
            q.push_back(m_e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("digits", 16'(Digits), 16'(e.digits));
            check("nibble", 16'(Nibble), 16'(e.nibble));
            check("blank",  16'(Blank),  16'(e.blank));
            check("ack",    16'(MsgAck), 16'(e.ack));
            check("busy",   16'(Busy),   16'(e.busy));
            check("tick",   16'(FrameTick), 16'(e.tick));
        end
        if (MsgAck && busy_prev) extra_acks++;
        busy_prev = Busy;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_tick_busy(input logic want_busy, input string tag);
        int k = 0;
        while (!(FrameTick === 1'b1 && Busy === want_busy) && k < 200) begin
            @(negedge clk); k++;
        end
        check(tag, 16'(FrameTick), 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int k;
        Reset = 1'b1; CreditData = 16'h0105; BlankZero = 1'b1;
        MsgData = '0; MsgReq = 1'b0;
        model_reset();
        #1;
        check("rst_digits", 16'(Digits), 16'hF);
        check("rst_nibble", 16'(Nibble), 16'h0);
        check("rst_blank",  16'(Blank),  16'h1);
        check("rst_ack",    16'(MsgAck), 16'h0);
        check("rst_busy",   16'(Busy),   16'h0);
        check("rst_tick",   16'(FrameTick), 16'h0);
        cycles(2);
        Reset = 1'b0;

        // first frame boundary lands on the 4th edge after release
        k = 0;
        while (FrameTick !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check("first_tick_cycle", 16'(k), 16'd4);
        cycles(8 * SD);

        CreditData = 16'h0007;
        cycles(8 * SD);
        BlankZero = 1'b0;
        cycles(8 * SD);

        // overlay accepted mid-frame, request held through the whole hold time
        CreditData = 16'h0105; BlankZero = 1'b1;
        wait_tick_busy(1'b0, "sync_tick");
        cycles(5);
        MsgReq = 1'b1; MsgData = 16'hE770;
        k = 0;
        while (MsgAck !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check("ack_seen", 16'(MsgAck), 16'd1);
        #1 MsgData = 16'h1234;
        wait_tick_busy(1'b1, "msg_tick");
        k = 0;
        while (Busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        check("hold_cycles", 16'(k), 16'(8 * SD));
        @(negedge clk);
        check("reack_next_cycle", 16'(MsgAck), 16'd1);
        check("no_extra_ack", 16'(extra_acks), 16'd0);
        #1 MsgReq = 1'b0;
        k = 0;
        while (Busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        check("second_release", 16'(Busy), 16'd0);

        // credit source change mid-frame must not tear
        CreditData = 16'h0105;
        cycles(8 * SD);
        wait_tick_busy(1'b0, "tear_tick");
        cycles(1);
        CreditData = 16'h0230;
        cycles(8 * SD);

        // reset during slot 2 of a message frame
        MsgReq = 1'b1; MsgData = 16'hE770;
        k = 0;
        while (MsgAck !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        #1 MsgReq = 1'b0;
        wait_tick_busy(1'b1, "msg_tick2");
        cycles(SD + 1);
        Reset = 1'b1;
        #1;
        check("mid_rst_digits", 16'(Digits), 16'hF);
        check("mid_rst_busy",   16'(Busy),   16'h0);
        check("mid_rst_ack",    16'(MsgAck), 16'h0);
        check("mid_rst_blank",  16'(Blank),  16'h1);
        q.delete();
        cycles(2);
        Reset = 1'b0;
        cycles(8 * SD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
